rs_encode_ctrl: RTL and testbench

- Sequencer for the systematic Reed-Solomon encoder in the HQC encapsulation path.
- Latches a K_BYTES message and owns the (N1-K)-bit parity register.
- Runs one LFSR step per cycle: computes the feedback ("gate") byte, drives it to an external GF(2^8) generator-coefficient multiplier bank, and folds the returned product array into the parity register with the shift-xor update.
- Emits the full N1-bit codeword (parity || message) with a start/done handshake.

---
 rtl/hqc_rs_pkg.sv | 28 ++
 rtl/cdw_xor_tmp.sv | 22 ++
 rtl/rs_encode_ctrl.sv | 130 +++++++++++++
 tb/tb_rs_encode_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hqc_rs_pkg.sv
// Shared definitions for the HQC Reed-Solomon encoder sequencer:
// per-parameter-set code sizes, the sequencer state encoding and sizing helpers.
package hqc_rs_pkg;

  localparam int HQC128_N1_BYTES = 46;
  localparam int HQC128_K_BYTES  = 16;
  localparam int HQC128_P_BYTES  = HQC128_N1_BYTES - HQC128_K_BYTES;

  localparam int HQC192_N1_BYTES = 56;
  localparam int HQC192_K_BYTES  = 24;
  localparam int HQC192_P_BYTES  = HQC192_N1_BYTES - HQC192_K_BYTES;

  localparam int HQC256_N1_BYTES = 90;
  localparam int HQC256_K_BYTES  = 32;
  localparam int HQC256_P_BYTES  = HQC256_N1_BYTES - HQC256_K_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rs_state_e;

  // Width of a down-counter that must hold values K_BYTES-1 .. 0.
  function automatic int cnt_width(input int n_bytes);
    return (n_bytes > 1) ? $clog2(n_bytes) : 1;
  endfunction

endpackage

// File: rtl/cdw_xor_tmp.sv
// Combinational shift-xor update of the RS parity register: every parity byte
// moves up one position and absorbs the matching generator product.
module cdw_xor_tmp #(
  parameter int P_BYTES = 30
) (
  input  logic [P_BYTES-1:0][7:0] par_i,
  input  logic [P_BYTES-1:0][7:0] tmp_i,
  output logic [P_BYTES-1:0][7:0] par_o,
  output logic [7:0]              fb_o
);

  // The byte shifted out of the top is the parity half of the next feedback.
  assign fb_o = par_i[P_BYTES-1];

  always_comb begin
    par_o[0] = tmp_i[0];
    for (int k = 1; k < P_BYTES; k++) begin
      par_o[k] = par_i[k-1] ^ tmp_i[k];
    end
  end

endmodule

// File: rtl/rs_encode_ctrl.sv
// Sequencer for the systematic RS encoder: latches the message, runs one LFSR
// step per cycle against an external GF(2^8) multiplier bank, emits parity||message.
module rs_encode_ctrl
  import hqc_rs_pkg::*;
#(
  parameter string parameter_set = "hqc128",
  parameter int    N1_BYTES = (parameter_set == "hqc256") ? HQC256_N1_BYTES :
                              (parameter_set == "hqc192") ? HQC192_N1_BYTES :
                                                            HQC128_N1_BYTES,
  parameter int    K_BYTES  = (parameter_set == "hqc256") ? HQC256_K_BYTES :
                              (parameter_set == "hqc192") ? HQC192_K_BYTES :
                                                            HQC128_K_BYTES,
  parameter int    N1       = 8 * N1_BYTES,
  parameter int    K        = 8 * K_BYTES,
  parameter int    P_BYTES  = N1_BYTES - K_BYTES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [K-1:0]         msg_in,
  output logic                 ready,
  output logic                 busy,
  output logic [7:0]           gate_out,
  input  logic [8*P_BYTES-1:0] tmp_arr_in,
  output logic                 done,
  output logic [N1-1:0]        cdw_out
);

  localparam int CNT_W = cnt_width(K_BYTES);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(K_BYTES - 1);

  rs_state_e                  state_q, state_d;
  logic [K_BYTES-1:0][7:0]    msg_q, msg_d;
  logic [P_BYTES-1:0][7:0]    par_q, par_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic [P_BYTES-1:0][7:0]    par_step;
  logic [P_BYTES-1:0][7:0]    tmp_arr;
  logic [7:0]                 par_fb;
  logic [7:0]                 gate;
  logic                       accept;

  assign tmp_arr = tmp_arr_in;

  cdw_xor_tmp #(
    .P_BYTES(P_BYTES)
  ) u_cdw_xor_tmp (
    .par_i (par_q),
    .tmp_i (tmp_arr),
    .par_o (par_step),
    .fb_o  (par_fb)
  );

  assign gate   = msg_q[cnt_q] ^ par_fb;
  assign accept = start && (state_q != RUN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    gate_out = 8'h00;
    unique case (state_q)
      IDLE: ready = 1'b1;
      RUN: begin
        busy     = 1'b1;
        gate_out = gate;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // tmp_arr_in only reaches the parity register while RUN, so an idle or
  // undriven multiplier bank cannot disturb the held codeword.
  always_comb begin
    msg_d = msg_q;
    par_d = par_q;
    cnt_d = cnt_q;
    if (accept) begin
      msg_d = msg_in;
      par_d = '0;
      cnt_d = CNT_START;
    end else if (state_q == RUN) begin
      par_d = par_step;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: the message and parity registers are reset because the codeword
  // output is architecturally visible and must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_q <= '0;
      par_q <= '0;
      cnt_q <= '0;
    end else begin
      msg_q <= msg_d;
      par_q <= par_d;
      cnt_q <= cnt_d;
    end
  end

  assign cdw_out = {msg_q, par_q};

endmodule

// File: tb/tb_rs_encode_ctrl.sv
// Directed bench for rs_encode_ctrl (hqc128) with a replicating multiplier stub:
// every generator product is taken equal to the gate byte.
module tb_rs_encode_ctrl;

  localparam int KB = 16;
  localparam int PB = 30;
  localparam int K  = 8 * KB;
  localparam int PW = 8 * PB;
  localparam int N1 = K + PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [K-1:0]  msg_in;
  logic          ready;
  logic          busy;
  logic [7:0]    gate_out;
  logic [PW-1:0] tmp_arr_in;
  logic          done;
  logic [N1-1:0] cdw_out;

  int checks = 0;
  int errors = 0;

  logic [7:0]    gate_log [KB];
  int            done_e;
  int            ready_lo;
  int            n_done;
  logic [N1-1:0] cdw_cap;

  always #5 clk = ~clk;

  assign tmp_arr_in = {PB{gate_out}};

  rs_encode_ctrl #(
    .parameter_set("hqc128")
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .msg_in     (msg_in),
    .ready      (ready),
    .busy       (busy),
    .gate_out   (gate_out),
    .tmp_arr_in (tmp_arr_in),
    .done       (done),
    .cdw_out    (cdw_out)
  );

  always @(negedge clk) begin
    checks++;
    if ((ready & busy) !== 1'b0) begin
      errors++;
      $display("FAIL ready_busy_excl: ready=%b busy=%b at %0t", ready, busy, $time);
    end
  end

  // Issues one start and records gate bytes, done timing and the codeword.
  // Edge 0 is the accepting edge; index e means "after edge e".
  task automatic run_encode(input logic [K-1:0] m);
    @(negedge clk);
    start  = 1'b1;
    msg_in = m;
    @(posedge clk);
    done_e   = -1;
    ready_lo = 0;
    n_done   = 0;
    cdw_cap  = '0;
    for (int e = 0; e < KB + 6; e++) begin
      @(negedge clk);
      if (e < KB) gate_log[e] = gate_out;
      if (!ready) ready_lo++;
      if (done) begin
        n_done++;
        if (done_e < 0) begin
          done_e  = e;
          cdw_cap = cdw_out;
        end
      end
      if (e == 0) begin
        start  = 1'b0;
        msg_in = ~m;
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    msg_in = '0;
    #12;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (gate_out !== 8'h00) begin errors++; $display("FAIL reset_gate: got %h want 00", gate_out); end
    checks++;
    if (cdw_out !== '0) begin errors++; $display("FAIL reset_cdw: got %h want 0", cdw_out); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b done=%b want ready=1 done=0", ready, done);
    end
  endtask

  task automatic test_zero_msg();
    run_encode('0);
    checks++;
    if (done_e !== KB) begin errors++; $display("FAIL zero_done_cycle: got %0d want %0d", done_e, KB); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", n_done); end
    checks++;
    if (ready_lo !== KB) begin errors++; $display("FAIL zero_ready_low: got %0d want %0d", ready_lo, KB); end
    checks++;
    if (cdw_cap !== '0) begin errors++; $display("FAIL zero_cdw: got %h want 0", cdw_cap); end
  endtask

  // Only byte 15 = 0x01: gates 01,01 then zeros; parity byte 14 = 01.
  task automatic test_top_byte();
    logic [K-1:0]  m;
    logic [PW-1:0] ep;
    logic [7:0]    eg;
    int            bad;
    m  = '0;
    m[8*15 +: 8] = 8'h01;
    ep = '0;
    ep[8*14 +: 8] = 8'h01;
    run_encode(m);
    bad = -1;
    for (int e = 0; e < KB; e++) begin
      eg = (e < 2) ? 8'h01 : 8'h00;
      if (gate_log[e] !== eg && bad < 0) bad = e;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL top_gate_seq: step %0d got %h want %h", bad, gate_log[bad], (bad < 2) ? 8'h01 : 8'h00);
    end
    checks++;
    if (done_e !== KB) begin errors++; $display("FAIL top_done_cycle: got %0d want %0d", done_e, KB); end
    checks++;
    if (cdw_cap !== {m, ep}) begin errors++; $display("FAIL top_cdw: got %h want %h", cdw_cap, {m, ep}); end
    checks++;
    if (cdw_cap[N1-1:PW] !== m) begin errors++; $display("FAIL top_msg_field: got %h want %h", cdw_cap[N1-1:PW], m); end
  endtask

  // Only byte 0 = 0xA5: the last step alone is non-zero, filling parity with A5.
  task automatic test_low_byte();
    logic [K-1:0]  m;
    logic [PW-1:0] ep;
    m  = '0;
    m[7:0] = 8'hA5;
    ep = {PB{8'hA5}};
    run_encode(m);
    checks++;
    if (gate_log[KB-1] !== 8'hA5 || gate_log[KB-2] !== 8'h00) begin
      errors++;
      $display("FAIL low_gate_last: got %h,%h want 00,a5", gate_log[KB-2], gate_log[KB-1]);
    end
    checks++;
    if (cdw_cap !== {m, ep}) begin errors++; $display("FAIL low_cdw: got %h want %h", cdw_cap, {m, ep}); end
  endtask

  // Held start: accepted at edge 0 and again in the DONE cycle (edge 17).
  task automatic test_back_to_back();
    logic [K-1:0]  ma, mb;
    logic [PW-1:0] pa, pb;
    logic [N1-1:0] c1, c2;
    int            d1, d2, nd;
    ma = '0; ma[8*15 +: 8] = 8'h01; ma[7:0] = 8'hA5;
    pa = {PB{8'hA5}}; pa[8*14 +: 8] = 8'hA4;
    mb = '0; mb[15:8] = 8'h3C;
    pb = '0; pb[7:0] = 8'h3C;
    d1 = -1; d2 = -1; nd = 0; c1 = '0; c2 = '0;
    @(negedge clk);
    start  = 1'b1;
    msg_in = ma;
    @(posedge clk);
    for (int e = 0; e < 41; e++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (d1 < 0) begin d1 = e; c1 = cdw_out; end
        else if (d2 < 0) begin d2 = e; c2 = cdw_out; end
      end
      if (e == 17) start = 1'b0;
      msg_in = (e == 16) ? mb : {$urandom, $urandom, $urandom, $urandom};
    end
    checks++;
    if (nd !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", nd); end
    checks++;
    if (d1 !== 16 || d2 !== 33) begin errors++; $display("FAIL b2b_done_cycles: got %0d,%0d want 16,33", d1, d2); end
    checks++;
    if (c1 !== {ma, pa}) begin errors++; $display("FAIL b2b_cdw_first: got %h want %h", c1, {ma, pa}); end
    checks++;
    if (c2 !== {mb, pb}) begin errors++; $display("FAIL b2b_cdw_second: got %h want %h", c2, {mb, pb}); end
    checks++;
    if (cdw_out !== {mb, pb}) begin errors++; $display("FAIL b2b_cdw_held: got %h want %h", cdw_out, {mb, pb}); end
  endtask

  // Reset in the fifth RUN cycle aborts silently; a later encode is unaffected.
  task automatic test_reset_mid_run();
    logic [K-1:0]  m, ma;
    logic [PW-1:0] ep;
    ma = '0; ma[8*15 +: 8] = 8'h01; ma[7:0] = 8'hA5;
    @(negedge clk);
    start  = 1'b1;
    msg_in = ma;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: ready=%b busy=%b want 1,0", ready, busy);
    end
    checks++;
    if (gate_out !== 8'h00) begin errors++; $display("FAIL midrst_gate: got %h want 00", gate_out); end
    checks++;
    if (cdw_out !== '0) begin errors++; $display("FAIL midrst_cdw: got %h want 0", cdw_out); end
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++;
    if (n_done !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", n_done); end
    m  = '0; m[15:8] = 8'h3C;
    ep = '0; ep[7:0] = 8'h3C;
    run_encode(m);
    checks++;
    if (done_e !== KB) begin errors++; $display("FAIL midrst_recover_cycle: got %0d want %0d", done_e, KB); end
    checks++;
    if (cdw_cap !== {m, ep}) begin errors++; $display("FAIL midrst_recover_cdw: got %h want %h", cdw_cap, {m, ep}); end
  endtask

  initial begin
    test_reset();
    test_zero_msg();
    test_top_byte();
    test_low_byte();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
